// File: rtl/fir_window_mac_pkg.sv
// fir_pkg: shared types and constants for the FIR window MAC and its helpers.
//   sample_t : signed sample/coefficient/output word
//   acc_t    : signed accumulator word
//   prod_t   : full-precision signed product
//   win_t    : packed TAPS-entry window (sample or coefficient array)
//   state_t  : MAC sequencer states
package fir_pkg;
  localparam int TAPS       = 64;
  localparam int DATA_WIDTH = 16;
  localparam int COEFF_FRAC = 15;
  localparam int ACC_WIDTH  = 40;
  localparam int IDX_W      = $clog2(TAPS);

  typedef logic signed [DATA_WIDTH-1:0]   sample_t;
  typedef logic signed [ACC_WIDTH-1:0]    acc_t;
  typedef logic signed [2*DATA_WIDTH-1:0] prod_t;
  typedef sample_t [TAPS-1:0]             win_t;
  typedef logic [IDX_W-1:0]               idx_t;

  localparam sample_t SAT_MAX    = sample_t'(2**(DATA_WIDTH-1) - 1);
  localparam sample_t SAT_MIN    = sample_t'(-(2**(DATA_WIDTH-1)));
  localparam acc_t    ROUND_HALF = acc_t'(2**(COEFF_FRAC-1));

  typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, DONE} state_t;
endpackage

// File: rtl/fir_window_mac_if.sv
// fir_window_mac_if: bundle between the sampler/coefficient side and the MAC.
//   ready_in    new-sample pulse
//   sample_in   circular sample window
//   offset_in   sampler write pointer (already advanced past the newest sample)
//   coeff_in    coefficients, [0] weights the newest sample
//   signal_out  filtered, rounded, saturated sample
//   valid_out   one-cycle strobe when signal_out updates
//   busy_out    computation in progress
//   overrun_out one-cycle pulse when a trigger was dropped
interface fir_window_mac_if;
  import fir_pkg::*;

  logic    ready_in;
  win_t    sample_in;
  idx_t    offset_in;
  win_t    coeff_in;
  sample_t signal_out;
  logic    valid_out;
  logic    busy_out;
  logic    overrun_out;

  modport master (
    output ready_in, sample_in, offset_in, coeff_in,
    input  signal_out, valid_out, busy_out, overrun_out
  );

  modport slave (
    input  ready_in, sample_in, offset_in, coeff_in,
    output signal_out, valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/fir_window_mac_round_saturate.sv
// round_saturate: combinational accumulator -> output sample conversion.
//   acc_i : Q(.COEFF_FRAC) accumulator value
//   sat_o : round-half-up, shifted and clamped to the sample range
module round_saturate
  import fir_pkg::*;
(
  input  acc_t    acc_i,
  output sample_t sat_o
);
  acc_t rnd;

  always_comb begin
    // Arithmetic shift floors, so adding half first gives round half up.
    rnd = (acc_i + ROUND_HALF) >>> COEFF_FRAC;
    if (rnd > acc_t'(SAT_MAX))      sat_o = SAT_MAX;
    else if (rnd < acc_t'(SAT_MIN)) sat_o = SAT_MIN;
    else                            sat_o = sample_t'(rnd);
  end
endmodule

// File: rtl/fir_window_mac.sv
// fir_window_mac: one-MAC-per-cycle FIR over the sampler's circular window.
//   clk_in : clock
//   rst_in : asynchronous active-high reset
//   bus    : fir_window_mac_if.slave (trigger, window, offset, coeffs in;
//            filtered sample, valid, busy, overrun out)
// Result appears TAPS+4 cycles after the accepted trigger.
module fir_window_mac
  import fir_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst_in,
  fir_window_mac_if.slave  bus
);
  state_t  state_q, state_d;
  idx_t    k_q, k_d;
  idx_t    base_q, base_d;
  acc_t    acc_q, acc_d;
  prod_t   prod_q, prod_d;
  sample_t sig_q, sig_d;
  logic    valid_q, valid_d;
  logic    ovr_q, ovr_d;

  idx_t    idx;
  sample_t rs_out;

  // Natural IDX_W-bit wrap gives the modulo-TAPS window index.
  assign idx = base_q - k_q;

  round_saturate u_rs (.acc_i(acc_q), .sat_o(rs_out));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      sig_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    sig_d   = sig_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.ready_in) state_d = LOAD;
      LOAD: begin
        base_d  = bus.offset_in - idx_t'(1);
        acc_d   = '0;
        // Zero product so the first MAC cycle's accumulate is a no-op.
        prod_d  = '0;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        prod_d = prod_t'(bus.coeff_in[k_q]) * prod_t'(bus.sample_in[idx]);
        acc_d  = acc_q + acc_t'(prod_q);
        k_d    = k_q + idx_t'(1);
        if (k_q == idx_t'(TAPS-1)) state_d = DRAIN;
      end
      DRAIN: begin
        acc_d   = acc_q + acc_t'(prod_q);
        state_d = DONE;
      end
      DONE: begin
        sig_d   = rs_out;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Triggers outside IDLE are dropped and flagged.
    if (bus.ready_in && state_q != IDLE) ovr_d = 1'b1;
  end

  assign bus.signal_out  = sig_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy_out    = (state_q != IDLE);
  assign bus.overrun_out = ovr_q;
endmodule

// File: doc/fir_window_mac.md
Name: fir_window_mac

Overview:
- Downstream consumer of the 64-entry circular sample window and its write offset produced by the sampler stage.
- On each new-sample pulse, computes y = sum over k of coeff[k] * x[newest - k] with one multiply-accumulate per cycle.
- Emits one rounded, saturated 16-bit filtered sample with a one-cycle valid strobe.
- Feeds the anti-noise output path; coefficients come from the coefficient register bank or the adaptive updater.

Parameters:
- TAPS, 64: window and coefficient count; power of two.
- DATA_WIDTH, 16: sample, coefficient and output width, signed.
- COEFF_FRAC, 15: fractional bits of the coefficients (Q1.15).
- ACC_WIDTH, 40: accumulator width; must be at least 2*DATA_WIDTH + clog2(TAPS).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- ready_in  input  1  new-sample pulse; the same strobe that drives the sampler.
- sample_in  input  TAPS x DATA_WIDTH signed  circular window from the sampler.
- offset_in  input  clog2(TAPS)  sampler write pointer.
- coeff_in  input  TAPS x DATA_WIDTH signed  coefficient array; coeff_in[0] weights the newest sample.
- signal_out  output  DATA_WIDTH signed  filtered sample.
- valid_out  output  1  one-cycle strobe; signal_out is new in this cycle.
- busy_out  output  1  high while a computation is in progress.
- overrun_out  output  1  one-cycle pulse when ready_in is dropped.

Behaviour:
- Clock and reset:
  - One clock, clk_in. rst_in is asynchronous and active-high.
  - Reset forces: state=IDLE, signal_out=0, valid_out=0, busy_out=0, overrun_out=0, accumulator=0, tap index=0.
- Window convention:
  - The sampler writes and increments offset on the ready_in edge.
  - One cycle after ready_in, the newest sample sits at index (offset_in - 1) mod TAPS.
  - Tap k reads index (base - k) mod TAPS; wrap-around uses natural clog2(TAPS)-bit truncation.
- FSM states and transitions (ready_in sampled in cycle T):
  - IDLE: ready_in=1 -> LOAD.
  - LOAD (T+1): capture base = offset_in - 1; clear accumulator; k=0 -> MAC.
  - MAC (T+2 .. T+TAPS+1): register product coeff_in[k] * sample_in[(base-k) mod TAPS] (2*DATA_WIDTH signed). Accumulate the previous cycle's product. Increment k; leave after k = TAPS-1 -> DRAIN.
  - DRAIN (T+TAPS+2): accumulate the last product -> DONE.
  - DONE (T+TAPS+3): round, saturate and register into signal_out -> IDLE.
- Latency and handshake:
  - valid_out=1 during cycle T+TAPS+4 (T+68 at default) for exactly one cycle.
  - signal_out holds its value until the next result.
  - busy_out=1 from T+1 through T+TAPS+3 (state != IDLE).
  - Minimum ready_in spacing is TAPS+4 cycles.
- Arithmetic:
  - Products are sign-extended into the ACC_WIDTH accumulator.
  - Rounding: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC (round half up).
  - Saturation clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Boundary conditions:
  - ready_in while busy_out=1: trigger dropped; overrun_out pulses the following cycle; the in-flight computation is unaffected.
  - ready_in in the same cycle valid_out is high: state is IDLE, so the trigger is accepted.
  - Coefficients are read live during MAC; updaters change coeff_in only while busy_out=0.
  - rst_in asserted mid-computation: immediate abort to reset values; no valid_out; first trigger after deassertion is accepted normally.
  - All-zero inputs give signal_out=0 with valid_out still pulsed.

Decomposition:
- Shared package fir_pkg:
  - sample_t (signed DATA_WIDTH), acc_t (signed ACC_WIDTH).
  - FSM state enum {IDLE, LOAD, MAC, DRAIN, DONE}.
  - Constants TAPS, COEFF_FRAC, SAT_MAX, SAT_MIN.
- One sub-module, round_saturate: combinational acc_t -> sample_t with rounding and clamping. Reused by the adaptive updater.

Test Plan:
- Impulse: coeff[0]=16384, all other coeffs 0; ready_in with newest sample 1000 -> signal_out=500, valid_out exactly 68 cycles after ready_in.
- Delay and wrap: offset_in=2 after trigger (base=1), coeff[5]=16384, sample_in[60]=-2000 -> signal_out=-1000 (reads index 60).
- Saturation: all coeffs 32767, all samples 32767 -> 32767. All samples -32768 -> -32768.
- Rounding: coeff[0]=1, newest sample 16384 -> 1; newest sample -16384 -> 0; newest sample -16385 -> -1.
- Overrun: second ready_in at T+10 -> overrun_out=1 at T+11, single valid_out at T+68 with the first result. Third ready_in at T+68 is accepted, valid_out at T+136.
- Reset mid-operation: rst_in at T+30 -> signal_out=0 and busy_out=0 immediately, no valid_out. Trigger after release produces a correct result 68 cycles later.
